stream_upsizer: RTL and testbench

STREAM_UPSIZER -- requirements
Module: stream_upsizer

---
 rtl/delta_counter.sv | 43 ++++
 rtl/stream_upsizer_checker.sv | 28 ++
 rtl/stream_upsizer.sv | 107 ++++++++++
 tb/tb_stream_upsizer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/delta_counter.sv
// Counter with step size delta_i. Clear has priority over load, and load has priority over count.
// The count wraps modulo 2**WIDTH.
module delta_counter #(
  parameter int unsigned WIDTH = 32'd4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             down_i,
  input  logic [WIDTH-1:0] delta_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_next;

  always_comb begin
    w_cnt_next = r_cnt;
    if (clear_i) begin
      w_cnt_next = {WIDTH{1'b0}};
    end else if (load_i) begin
      w_cnt_next = d_i;
    end else if (en_i) begin
      w_cnt_next = down_i ? (r_cnt - delta_i) : (r_cnt + delta_i);
    end else begin
      w_cnt_next = r_cnt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= {WIDTH{1'b0}};
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign q_o = r_cnt;

endmodule

// File: rtl/stream_upsizer_checker.sv
// Protocol assertions for stream_upsizer.
// It watches the output hold behaviour, the lane counter range and the ready/valid relationship.
module stream_upsizer_checker #(
  parameter int unsigned InWidth  = 32'd8,
  parameter int unsigned Ratio    = 32'd4,
  parameter int unsigned CntWidth = 32'd2
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  input logic                     valid_o,
  input logic                     ready_i,
  input logic                     ready_o,
  input logic [InWidth*Ratio-1:0] data_o,
  input logic [Ratio-1:0]         strb_o,
  input logic                     last_o,
  input logic [CntWidth-1:0]      cnt_q
);

  a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i) |=> ($stable(data_o) && $stable(strb_o) && $stable(last_o)));

  a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (32'(cnt_q) < Ratio));

  a_no_ready_when_blocked: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(ready_o && valid_o && !ready_i));

endmodule

// File: rtl/stream_upsizer.sv
// Packs Ratio narrow input beats into one wide output word.
// A last_i beat closes a partial word early, and its unwritten lanes read as zero.
module stream_upsizer #(
  parameter int unsigned InWidth = 32'd8,
  parameter int unsigned Ratio   = 32'd4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [InWidth-1:0]       data_i,
  input  logic                     last_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [InWidth*Ratio-1:0] data_o,
  output logic [Ratio-1:0]         strb_o,
  output logic                     last_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     busy_o
);

  localparam int unsigned CntWidth = (Ratio > 32'd1) ? $clog2(Ratio) : 32'd1;
  localparam int unsigned OutWidth = InWidth * Ratio;

  if (Ratio < 32'd2) begin : g_ratio_check
    $fatal(1, "stream_upsizer: Ratio must be at least 2");
  end

  logic [CntWidth-1:0] w_cnt_q;
  logic                w_beat;
  logic                w_word_xfer;
  logic                w_complete;
  logic                w_cnt_clear;
  logic [OutWidth-1:0] w_merge_data;
  logic [Ratio-1:0]    w_merge_strb;
  logic [OutWidth-1:0] r_acc_data;
  logic [Ratio-1:0]    r_acc_strb;
  logic [OutWidth-1:0] r_data_o;
  logic [Ratio-1:0]    r_strb_o;
  logic                r_last_o;
  logic                r_valid_o;

  // The output slot is free when it is empty or is being drained in this cycle.
  assign ready_o     = !r_valid_o || ready_i;
  assign w_beat      = valid_i && ready_o;
  assign w_word_xfer = r_valid_o && ready_i;
  assign w_complete  = w_beat && ((w_cnt_q == CntWidth'(Ratio - 32'd1)) || last_i);
  assign w_cnt_clear = flush_i || w_complete;

  always_comb begin
    w_merge_data = r_acc_data | (OutWidth'(data_i) << (w_cnt_q * InWidth));
    w_merge_strb = r_acc_strb | (Ratio'(1'b1) << w_cnt_q);
  end

  delta_counter #(
    .WIDTH (CntWidth)
  ) u_lane_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (w_cnt_clear),
    .en_i    (w_beat),
    .load_i  (1'b0),
    .down_i  (1'b0),
    .delta_i (CntWidth'(1'b1)),
    .d_i     ({CntWidth{1'b0}}),
    .q_o     (w_cnt_q)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc_data <= {OutWidth{1'b0}};
      r_acc_strb <= {Ratio{1'b0}};
    end else if (w_cnt_clear) begin
      r_acc_data <= {OutWidth{1'b0}};
      r_acc_strb <= {Ratio{1'b0}};
    end else if (w_beat) begin
      r_acc_data <= w_merge_data;
      r_acc_strb <= w_merge_strb;
    end
  end

  // Reloading while the current word drains keeps valid_o high, so no bubble is inserted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data_o  <= {OutWidth{1'b0}};
      r_strb_o  <= {Ratio{1'b0}};
      r_last_o  <= 1'b0;
      r_valid_o <= 1'b0;
    end else if (flush_i) begin
      r_valid_o <= 1'b0;
    end else if (w_complete) begin
      r_data_o  <= w_merge_data;
      r_strb_o  <= w_merge_strb;
      r_last_o  <= last_i;
      r_valid_o <= 1'b1;
    end else if (w_word_xfer) begin
      r_valid_o <= 1'b0;
    end
  end

  assign data_o  = r_data_o;
  assign strb_o  = r_strb_o;
  assign last_o  = r_last_o;
  assign valid_o = r_valid_o;
  assign busy_o  = (w_cnt_q != {CntWidth{1'b0}}) || r_valid_o;

endmodule

// File: tb/tb_stream_upsizer.sv
// Scoreboard bench for stream_upsizer with InWidth=8 and Ratio=4.
// Directed stimulus pushes the expected words into a queue, and a monitor pops and compares them.
module tb_stream_upsizer;

  localparam int unsigned InWidth = 8;
  localparam int unsigned Ratio   = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } word_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic [7:0]  data_i;
  logic        last_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic [3:0]  strb_o;
  logic        last_o;
  logic        valid_o;
  logic        ready_i;
  logic        busy_o;

  word_t sb_q[$];
  word_t exp_w;
  int    tests_run    = 0;
  int    tests_failed = 0;
  int    cyc          = 0;
  int    t_start;

  stream_upsizer #(.InWidth(InWidth), .Ratio(Ratio)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .data_i  (data_i),
    .last_i  (last_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .strb_o  (strb_o),
    .last_o  (last_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .busy_o  (busy_o)
  );

  stream_upsizer_checker #(.InWidth(InWidth), .Ratio(Ratio), .CntWidth(2)) u_chk (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .strb_o  (strb_o),
    .last_o  (last_o),
    .cnt_q   (dut.w_cnt_q)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] s, input logic l);
    word_t w;
    w.data = d;
    w.strb = s;
    w.last = l;
    sb_q.push_back(w);
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    bit done;
    done    = 1'b0;
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk_i);
      if (ready_o) done = 1'b1;
      @(posedge clk_i);
      #1;
    end
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: got no ready_o, expected beat 0x%0h accepted", d);
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    last_i  = 1'b0;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Monitor: every word handshake is checked against the head of the scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni && valid_o && ready_i) begin
      if (sb_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_word: got 0x%0h, expected none", data_o);
      end else begin
        exp_w = sb_q.pop_front();
        chk("word_data", data_o, exp_w.data);
        chk("word_strb", 32'(strb_o), 32'(exp_w.strb));
        chk("word_last", 32'(last_o), 32'(exp_w.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    data_i  = 8'h00;
    last_i  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    #12;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data",  data_o, 32'd0);
    chk("rst_strb",  32'(strb_o), 32'd0);
    chk("rst_busy",  32'(busy_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle(2);

    // Full word, with a latency check on valid_o.
    push(32'h44332211, 4'hF, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    chk("lat_before", 32'(valid_o), 32'd0);
    send(8'h44, 1'b0);
    chk("lat_after", 32'(valid_o), 32'd1);
    idle(3);

    // Partial word closed by last_i.
    push(32'h0000BBAA, 4'h3, 1'b1);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    idle(3);

    // Backpressure: a held word blocks further beats.
    ready_i = 1'b0;
    push(32'h13121110, 4'hF, 1'b0);
    send(8'h10, 1'b0);
    send(8'h11, 1'b0);
    send(8'h12, 1'b0);
    send(8'h13, 1'b0);
    valid_i = 1'b1;
    data_i  = 8'h20;
    repeat (3) @(posedge clk_i);
    #1;
    chk("bp_ready", 32'(ready_o), 32'd0);
    chk("bp_data",  data_o, 32'h13121110);
    chk("bp_busy",  32'(busy_o), 32'd1);
    ready_i = 1'b1;
    push(32'h23222120, 4'hF, 1'b0);
    send(8'h20, 1'b0);
    send(8'h21, 1'b0);
    send(8'h22, 1'b0);
    send(8'h23, 1'b0);
    idle(3);

    // Back-to-back single-beat words: the output reloads without a bubble.
    push(32'h00000077, 4'h1, 1'b1);
    push(32'h00000088, 4'h1, 1'b1);
    send(8'h77, 1'b1);
    chk("nb_valid1", 32'(valid_o), 32'd1);
    send(8'h88, 1'b1);
    chk("nb_valid2", 32'(valid_o), 32'd1);
    chk("nb_data2",  data_o, 32'h00000088);
    idle(3);

    // Continuous stream of 12 beats, one beat per cycle.
    push(32'h04030201, 4'hF, 1'b0);
    push(32'h08070605, 4'hF, 1'b0);
    push(32'h0C0B0A09, 4'hF, 1'b0);
    t_start = cyc;
    for (int i = 1; i <= 12; i++) send(8'(i), 1'b0);
    chk("stream_cycles", 32'(cyc - t_start), 32'd12);
    idle(3);

    // Flush drops the partial word and the beat offered during the flush cycle.
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    flush_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'h99;
    last_i  = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    last_i  = 1'b0;
    chk("flush_busy", 32'(busy_o), 32'd0);
    push(32'h04030201, 4'hF, 1'b0);
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    idle(3);

    // Reset in the middle of a word.
    send(8'hE1, 1'b0);
    send(8'hE2, 1'b0);
    send(8'hE3, 1'b0);
    rst_ni = 1'b0;
    #1;
    chk("mrst_valid", 32'(valid_o), 32'd0);
    chk("mrst_data",  data_o, 32'd0);
    chk("mrst_strb",  32'(strb_o), 32'd0);
    chk("mrst_last",  32'(last_o), 32'd0);
    chk("mrst_busy",  32'(busy_o), 32'd0);
    chk("mrst_ready", 32'(ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    push(32'hD4D3D2D1, 4'hF, 1'b0);
    send(8'hD1, 1'b0);
    send(8'hD2, 1'b0);
    send(8'hD3, 1'b0);
    send(8'hD4, 1'b0);
    idle(5);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
